// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage core pipeline control slice.
// Holds the forwarding-select encodings, the hazard controller state
// encoding and the NOP instruction word used when a stage is killed.
package pipe_pkg;

  // EX-stage operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Instruction word loaded into a killed/bubbled pipeline register
  localparam logic [31:0] NOP_INSTR = 32'b0;

  // Hazard controller states
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage forwarding select for a single source operand.
// Ports:
//   i_ex_rs          : EX-stage source register index
//   i_mem_rd/_we     : MEM-stage destination and write flag
//   i_wb_rd/_we      : WB-stage destination and write flag
//   o_sel            : FWD_RF / FWD_MEM / FWD_WB
// Purely combinational; the younger MEM result wins over WB.
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW = 3
) (
  input  logic [REG_AW-1:0] i_ex_rs,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_mem_we,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_we,
  output logic [1:0]        o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  // Register 0 is hard-wired zero, so a write to it is never forwarded
  assign w_mem_hit = i_mem_we && (i_mem_rd != '0) && (i_mem_rd == i_ex_rs);
  assign w_wb_hit  = i_wb_we  && (i_wb_rd  != '0) && (i_wb_rd  == i_ex_rs);

  always_comb begin
    o_sel = FWD_RF;
    if (w_mem_hit)     o_sel = FWD_MEM;
    else if (w_wb_hit) o_sel = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline controller for the 5-stage RISC core.
// Sequences the post-reset flush, the load-use interlock and the
// data-memory wait/timeout, drives IF/ID stall/kill1, PC enable,
// ID/EX bubble insert and the whole-pipe freeze, generates EX forwarding
// selects and keeps saturating stall/flush performance counters.
// Ports:
//   clk, reset                    : clock, async active-high reset
//   id_rs1/2, id_use1/2           : ID-stage sources and read flags
//   ex_rd, ex_mem_read, ex_reg_write : EX-stage destination info
//   mem_rd/mem_reg_write, wb_rd/wb_reg_write : later-stage writers
//   ex_rs1/2                      : EX-stage sources for forwarding
//   id_redirect                   : branch/jump taken in ID
//   dmem_req, dmem_ready          : data-memory handshake
//   stall_pc, stall, kill1, bubble_idex, freeze : pipeline controls
//   fwd_a, fwd_b                  : forwarding selects
//   mem_timeout                   : sticky memory timeout flag
//   stall_cnt, flush_cnt          : saturating performance counters
// Control outputs are combinational from state and inputs; only the
// state, the wait counter, the counters and the timeout flag are flops.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW   = 3,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic              id_redirect,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              stall_pc,
  output logic              stall,
  output logic              kill1,
  output logic              bubble_idex,
  output logic              freeze,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int WCW = $clog2(WAIT_MAX + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  hz_state_t      r_state;
  hz_state_t      w_next_state;
  logic [WCW-1:0] r_wait_cnt;
  logic [WCW-1:0] w_wait_next;
  logic           w_timeout_set;
  logic           w_load_use;

  // A load whose result is needed by the instruction in ID cannot be
  // forwarded in time; x0 never creates a dependency.
  assign w_load_use = ex_mem_read && ex_reg_write && (ex_rd != '0) &&
                      ((id_use1 && (id_rs1 == ex_rd)) ||
                       (id_use2 && (id_rs2 == ex_rd)));

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .i_ex_rs  (ex_rs1),
    .i_mem_rd (mem_rd),
    .i_mem_we (mem_reg_write),
    .i_wb_rd  (wb_rd),
    .i_wb_we  (wb_reg_write),
    .o_sel    (fwd_a)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .i_ex_rs  (ex_rs2),
    .i_mem_rd (mem_rd),
    .i_mem_we (mem_reg_write),
    .i_wb_rd  (wb_rd),
    .i_wb_we  (wb_reg_write),
    .o_sel    (fwd_b)
  );

  always_comb begin
    stall_pc      = 1'b0;
    stall         = 1'b0;
    kill1         = 1'b0;
    bubble_idex   = 1'b0;
    freeze        = 1'b0;
    w_next_state  = r_state;
    w_wait_next   = r_wait_cnt;
    w_timeout_set = 1'b0;
    case (r_state)
      ST_BOOT: begin
        // Flush whatever the IF/ID register powered up with
        kill1        = 1'b1;
        w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (dmem_req && !dmem_ready) begin
          freeze       = 1'b1;
          stall        = 1'b1;
          stall_pc     = 1'b1;
          w_next_state = ST_WAIT;
          w_wait_next  = WCW'(1);
        end else if (w_load_use) begin
          // Redirect is dropped here; the branch stays in ID and is
          // re-evaluated next cycle, which keeps kill1 away from stall.
          stall       = 1'b1;
          stall_pc    = 1'b1;
          bubble_idex = 1'b1;
        end else if (id_redirect) begin
          kill1 = 1'b1;
        end
      end
      ST_WAIT: begin
        if (dmem_ready) begin
          w_next_state = ST_RUN;
          w_wait_next  = '0;
        end else if (r_wait_cnt == WCW'(WAIT_MAX)) begin
          // Give up on the access: release the pipe and flag it
          w_timeout_set = 1'b1;
          w_next_state  = ST_RUN;
          w_wait_next   = '0;
        end else begin
          freeze      = 1'b1;
          stall       = 1'b1;
          stall_pc    = 1'b1;
          w_wait_next = r_wait_cnt + WCW'(1);
        end
      end
      default: begin
        w_next_state = ST_BOOT;
        w_wait_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_BOOT;
      r_wait_cnt  <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_next;
      if (w_timeout_set) mem_timeout <= 1'b1;
      if (stall && (r_state != ST_BOOT)) stall_cnt <= sat_inc(stall_cnt);
      if (kill1 && (r_state == ST_RUN))  flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int REG_AW   = 3;
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 16;

  // control vector order: {stall_pc, stall, kill1, bubble_idex, freeze}
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_KILL = 5'b00100;
  localparam logic [4:0] C_LU   = 5'b11010;
  localparam logic [4:0] C_FRZ  = 5'b11001;

  logic              clk;
  logic              reset;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd, ex_rs1, ex_rs2;
  logic              id_use1, id_use2, ex_mem_read, ex_reg_write;
  logic              mem_reg_write, wb_reg_write, id_redirect;
  logic              dmem_req, dmem_ready;
  logic              stall_pc, stall, kill1, bubble_idex, freeze, mem_timeout;
  logic [1:0]        fwd_a, fwd_b;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  typedef struct {
    string            tag;
    logic [4:0]       ctrl;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic             tmo;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  logic [CNT_W-1:0] exp_sc = '0;
  logic [CNT_W-1:0] exp_fc = '0;

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .id_redirect(id_redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_pc(stall_pc), .stall(stall), .kill1(kill1),
    .bubble_idex(bubble_idex), .freeze(freeze),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr_inputs();
    id_rs1 = '0; id_rs2 = '0; id_use1 = 0; id_use2 = 0;
    ex_rd = '0; ex_mem_read = 0; ex_reg_write = 0;
    mem_rd = '0; mem_reg_write = 0; wb_rd = '0; wb_reg_write = 0;
    ex_rs1 = '0; ex_rs2 = '0; id_redirect = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic compare_head();
    exp_t e;
    logic [4:0] obs;
    e = sb.pop_front();
    obs = {stall_pc, stall, kill1, bubble_idex, freeze};
    total++;
    assert (obs === e.ctrl) else begin
      bad++; $error("FAIL %s ctrl got=%b want=%b", e.tag, obs, e.ctrl);
    end
    total++;
    assert ({fwd_a, fwd_b} === {e.fa, e.fb}) else begin
      bad++; $error("FAIL %s fwd got=%b/%b want=%b/%b", e.tag, fwd_a, fwd_b, e.fa, e.fb);
    end
    total++;
    assert (mem_timeout === e.tmo) else begin
      bad++; $error("FAIL %s mem_timeout got=%b want=%b", e.tag, mem_timeout, e.tmo);
    end
    total++;
    assert (stall_cnt === e.sc) else begin
      bad++; $error("FAIL %s stall_cnt got=%0d want=%0d", e.tag, stall_cnt, e.sc);
    end
    total++;
    assert (flush_cnt === e.fc) else begin
      bad++; $error("FAIL %s flush_cnt got=%0d want=%0d", e.tag, flush_cnt, e.fc);
    end
  endtask

  // Inputs are already driven (1 time unit after a rising edge). Push the
  // expectation, sample mid-cycle, then advance the bench's counter model
  // and move to just after the next rising edge.
  task automatic step(input string tag, input logic [4:0] ctrl,
                      input logic [1:0] fa, input logic [1:0] fb,
                      input logic tmo, input bit boot);
    exp_t e;
    e.tag = tag; e.ctrl = ctrl; e.fa = fa; e.fb = fb; e.tmo = tmo;
    e.sc = exp_sc; e.fc = exp_fc;
    sb.push_back(e);
    #3;
    compare_head();
    if (ctrl[3] && !boot && exp_sc != '1) exp_sc = exp_sc + 1'b1;
    if (ctrl[2] && !boot && exp_fc != '1) exp_fc = exp_fc + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    total++;
    assert (mem_timeout === 1'b0) else begin
      bad++; $error("FAIL %s mem_timeout got=%b want=0", tag, mem_timeout);
    end
    total++;
    assert (stall_cnt === '0 && flush_cnt === '0) else begin
      bad++; $error("FAIL %s counters got=%0d/%0d want=0/0", tag, stall_cnt, flush_cnt);
    end
  endtask

  initial begin
    clr_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    check_reset_state("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // post-reset flush: one kill1 cycle, not counted
    step("boot",      C_KILL, 2'b00, 2'b00, 0, 1);
    step("run_idle",  C_NONE, 2'b00, 2'b00, 0, 0);
    step("run_idle2", C_NONE, 2'b00, 2'b00, 0, 0);

    // load-use interlock
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 3; id_rs1 = 3; id_use1 = 1;
    step("lu_rs1",    C_LU,   2'b00, 2'b00, 0, 0);
    clr_inputs();
    step("lu_after",  C_NONE, 2'b00, 2'b00, 0, 0);
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 0; id_rs1 = 0; id_use1 = 1;
    step("lu_rd0",    C_NONE, 2'b00, 2'b00, 0, 0);
    ex_rd = 3; id_rs1 = 3; id_use1 = 0;
    step("lu_nouse",  C_NONE, 2'b00, 2'b00, 0, 0);
    id_rs2 = 3; id_use2 = 1;
    step("lu_rs2",    C_LU,   2'b00, 2'b00, 0, 0);
    ex_reg_write = 0;
    step("lu_nowr",   C_NONE, 2'b00, 2'b00, 0, 0);
    clr_inputs();

    // redirect, and redirect suppressed by load-use
    id_redirect = 1;
    step("redir",     C_KILL, 2'b00, 2'b00, 0, 0);
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 3; id_rs1 = 3; id_use1 = 1;
    step("lu_redir",  C_LU,   2'b00, 2'b00, 0, 0);
    clr_inputs();
    step("redir_aft", C_NONE, 2'b00, 2'b00, 0, 0);

    // memory wait: 4 frozen cycles then ready
    dmem_req = 1; dmem_ready = 0;
    step("wait1",     C_FRZ,  2'b00, 2'b00, 0, 0);
    id_redirect = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 3; id_rs1 = 3; id_use1 = 1;
    step("wait2",     C_FRZ,  2'b00, 2'b00, 0, 0);
    id_redirect = 0; ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0; id_rs1 = 0; id_use1 = 0;
    step("wait3",     C_FRZ,  2'b00, 2'b00, 0, 0);
    step("wait4",     C_FRZ,  2'b00, 2'b00, 0, 0);
    dmem_ready = 1;
    step("ready",     C_NONE, 2'b00, 2'b00, 0, 0);
    clr_inputs();
    step("ready_aft", C_NONE, 2'b00, 2'b00, 0, 0);

    // forwarding
    mem_reg_write = 1; mem_rd = 5; wb_reg_write = 1; wb_rd = 5; ex_rs1 = 5; ex_rs2 = 5;
    step("fwd_mem",   C_NONE, 2'b01, 2'b01, 0, 0);
    mem_rd = 4;
    step("fwd_wb",    C_NONE, 2'b10, 2'b10, 0, 0);
    mem_rd = 5; mem_reg_write = 0;
    step("fwd_memnw", C_NONE, 2'b10, 2'b10, 0, 0);
    mem_reg_write = 1; mem_rd = 0; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
    step("fwd_rd0",   C_NONE, 2'b00, 2'b00, 0, 0);
    mem_rd = 5; wb_rd = 6; ex_rs1 = 5; ex_rs2 = 6;
    step("fwd_split", C_NONE, 2'b01, 2'b10, 0, 0);
    ex_rs1 = 7; ex_rs2 = 7;
    step("fwd_none",  C_NONE, 2'b00, 2'b00, 0, 0);
    clr_inputs();

    // memory timeout: 15 frozen cycles, then freeze drops and flag sets
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < WAIT_MAX; i++)
      step("tmo_wait", C_FRZ, 2'b00, 2'b00, 0, 0);
    step("tmo_fire",  C_NONE, 2'b00, 2'b00, 0, 0);
    dmem_req = 0;
    step("tmo_stk1",  C_NONE, 2'b00, 2'b00, 1, 0);
    id_redirect = 1;
    step("tmo_stk2",  C_KILL, 2'b00, 2'b00, 1, 0);
    clr_inputs();

    // asynchronous reset mid-operation clears flag and counters
    reset = 1'b1;
    #2;
    exp_sc = '0; exp_fc = '0;
    check_reset_state("reset_mid");
    @(posedge clk); #1;
    reset = 1'b0;
    step("boot2",     C_KILL, 2'b00, 2'b00, 0, 1);
    step("run2",      C_NONE, 2'b00, 2'b00, 0, 0);

    total++;
    assert (sb.size() == 0) else begin
      bad++; $error("FAIL scoreboard leftover got=%0d want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
